// File: rtl/xif_result_arbiter.sv
// rtl/xif_result_arbiter.sv - N-channel buffered result collector for the CORE-V-XIF result port
//
// Each producer channel pushes {id, data, rd} into its own circular FIFO. The
// arbiter moves one FIFO head per cycle into a registered result port that
// follows the result_valid/result_ready handshake.
//
// Build option: XIF_RR_ARB_EN selects round-robin arbitration. When it is not
// defined, the lowest-index non-empty channel wins and no pointer register exists.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   ch_valid / ch_ready      per-channel push handshake (ready = FIFO not full)
//   ch_id / ch_data / ch_rd  per-channel packed payloads, channel i at [i*W +: W]
//   ch_count                 per-channel registered FIFO occupancy
//   result_valid/ready       XIF result handshake
//   result_id/data/rd        registered result payload
//   result_ch                channel that produced the presented result
module xif_result_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int X_ID_WIDTH = 4,
    parameter int FLEN       = 32,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1),
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic [NUM_CH*X_ID_WIDTH-1:0] ch_id,
    input  logic [NUM_CH*FLEN-1:0]   ch_data,
    input  logic [NUM_CH*5-1:0]      ch_rd,
    output logic [NUM_CH*CNT_W-1:0]  ch_count,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [X_ID_WIDTH-1:0]    result_id,
    output logic [FLEN-1:0]          result_data,
    output logic [4:0]               result_rd,
    output logic [CH_W-1:0]          result_ch
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int EW    = X_ID_WIDTH + FLEN + 5;

    logic [EW-1:0]    mem_q  [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q [NUM_CH];
    logic [PTR_W-1:0] rptr_q [NUM_CH];
    logic [CNT_W-1:0] cnt_q  [NUM_CH];

    logic                  valid_q;
    logic [X_ID_WIDTH-1:0] id_q;
    logic [FLEN-1:0]       data_q;
    logic [4:0]            rd_q;
    logic [CH_W-1:0]       ch_q;

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] nonempty;
    logic [NUM_CH-1:0] pop;
    logic              any_req;
    logic [CH_W-1:0]   winner;
    logic              load_en;
    logic [EW-1:0]     head;

`ifdef XIF_RR_ARB_EN
    logic [CH_W-1:0] ptr_q;
    logic [CH_W-1:0] ptr_d;
`endif

    // Ready depends on the registered count only, so a full FIFO refuses a push
    // even when its head is being popped in the same cycle.
    always_comb begin
        ch_ready = '0;
        push     = '0;
        nonempty = '0;
        ch_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ready[i] = (cnt_q[i] != CNT_W'(FIFO_DEPTH));
            push[i]     = ch_valid[i] && ch_ready[i];
            nonempty[i] = (cnt_q[i] != '0);
            ch_count[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    // Eligibility uses registered counts; a same-cycle push is not visible.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
`ifdef XIF_RR_ARB_EN
        for (int k = 0; k < NUM_CH; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!any_req && nonempty[idx]) begin
                any_req = 1'b1;
                winner  = CH_W'(idx);
            end
        end
        ptr_d = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + CH_W'(1);
`else
        for (int k = 0; k < NUM_CH; k++) begin
            if (!any_req && nonempty[k]) begin
                any_req = 1'b1;
                winner  = CH_W'(k);
            end
        end
`endif
    end

    assign load_en = !valid_q || result_ready;
    assign pop     = (load_en && any_req) ? (NUM_CH'(1) << winner) : '0;
    assign head    = mem_q[winner][rptr_q[winner]];

    // Storage needs no reset: an entry is only read after its write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= {ch_id[i*X_ID_WIDTH +: X_ID_WIDTH],
                                        ch_data[i*FLEN +: FLEN],
                                        ch_rd[i*5 +: 5]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            valid_q <= 1'b0;
            id_q    <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            ch_q    <= '0;
`ifdef XIF_RR_ARB_EN
            ptr_q   <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) wptr_q[i] <= wptr_q[i] + PTR_W'(1);
                if (pop[i])  rptr_q[i] <= rptr_q[i] + PTR_W'(1);
                case ({push[i], pop[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    2'b01:   cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                    default: cnt_q[i] <= cnt_q[i];
                endcase
            end
            // Payload holds its last value when the port drains empty.
            if (load_en) begin
                if (any_req) begin
                    valid_q <= 1'b1;
                    id_q    <= head[EW-1 -: X_ID_WIDTH];
                    data_q  <= head[FLEN+4:5];
                    rd_q    <= head[4:0];
                    ch_q    <= winner;
`ifdef XIF_RR_ARB_EN
                    ptr_q   <= ptr_d;
`endif
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign result_valid = valid_q;
    assign result_id    = id_q;
    assign result_data  = data_q;
    assign result_rd    = rd_q;
    assign result_ch    = ch_q;

endmodule
